// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM states, byte roles, phases and bus bit constants
// used by i2c_master and i2c_slave.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_TXBYTE,
    ST_RXACK,
    ST_RSTART,
    ST_RXBYTE,
    ST_TXNACK,
    ST_STOP
  } state_t;

  // Which byte of the transaction the master has just sent.
  typedef enum logic [1:0] {
    B_DEV_W,
    B_REG,
    B_WDATA,
    B_DEV_R
  } byte_t;

  // Quarters of one SCL bit slot. SCL is low in SETUP and FALL and high in
  // RISE and HIGH, so slot boundaries always fall while SCL is low.
  typedef enum logic [1:0] {
    PH_SETUP,
    PH_RISE,
    PH_HIGH,
    PH_FALL
  } phase_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;
  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;

endpackage

// File: rtl/i2c_master_if.sv
// Command/response bundle of the I2C master; "master" is the requester side,
// "slave" is the i2c_master block that serves the command.
interface i2c_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_wdata;
  logic       done;
  logic       ack_err;
  logic [7:0] rdata;

  modport master (
    output cmd_valid, cmd_rw, cmd_dev, cmd_reg, cmd_wdata,
    input  cmd_ready, done, ack_err, rdata
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_dev, cmd_reg, cmd_wdata,
    output cmd_ready, done, ack_err, rdata
  );
endinterface

// File: rtl/i2c_master_clkgen.sv
// Quarter-phase generator for the I2C master: DIV clk cycles per quarter.
// Define I2C_MASTER_STRETCH_EN to hold the RISE quarter until scl_i reads 1.
module i2c_master_clkgen
  import i2c_pkg::*;
#(
  parameter int DIV = 63
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   run,
  input  logic   scl_i,
  output phase_t phase,
  output logic   tick
);

  localparam int          CW      = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  phase_t        phase_q;
  logic          hold;

`ifdef I2C_MASTER_STRETCH_EN
  // A slave holding SCL low delays the start of the high-phase count.
  assign hold = (phase_q == PH_RISE) && !scl_i;
`else
  logic unused_scl_i;
  assign unused_scl_i = scl_i;
  assign hold         = 1'b0;
`endif

  assign tick  = run && !hold && (cnt_q == CNT_MAX);
  assign phase = phase_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= PH_SETUP;
    end else if (!run) begin
      cnt_q   <= '0;
      phase_q <= PH_SETUP;
    end else if (!hold) begin
      if (cnt_q == CNT_MAX) begin
        cnt_q   <= '0;
        phase_q <= phase_t'(phase_q + 2'd1);
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_master.sv
// Single-register I2C master: write or read one register of a 7-bit device.
// Clock stretching is honoured only with I2C_MASTER_STRETCH_EN defined.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int DIV = 63
) (
  input  logic           clk,
  input  logic           rst_n,
  i2c_master_if.slave    host,
  output logic           scl_oe,
  input  logic           scl_i,
  output logic           sda_oe,
  input  logic           sda_i
);

  state_t     state_q, state_d;
  byte_t      byte_q, byte_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic       rw_q, rw_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] wdata_q, wdata_d;
  logic       ack_q, ack_d;
  logic [7:0] rdata_q, rdata_d;
  logic       ack_err_q, ack_err_d;
  logic       done_q, done_d;
  logic       rdy_q;

  phase_t phase;
  logic   tick;
  logic   slot_end;
  logic   rise_end;

  i2c_master_clkgen #(.DIV(DIV)) u_clkgen (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (state_q != ST_IDLE),
    .scl_i (scl_i),
    .phase (phase),
    .tick  (tick)
  );

  assign slot_end = tick && (phase == PH_FALL);
  assign rise_end = tick && (phase == PH_RISE);

  // rdy_q keeps cmd_ready low while reset is held and for no longer.
  assign host.cmd_ready = rdy_q && (state_q == ST_IDLE);
  assign host.done      = done_q;
  assign host.ack_err   = ack_err_q;
  assign host.rdata     = rdata_q;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    state_d   = state_q;
    byte_d    = byte_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    rw_d      = rw_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    ack_d     = ack_q;
    rdata_d   = rdata_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: if (host.cmd_valid && host.cmd_ready) begin
        rw_d      = host.cmd_rw;
        dev_d     = host.cmd_dev;
        reg_d     = host.cmd_reg;
        wdata_d   = host.cmd_wdata;
        sh_d      = {host.cmd_dev, RW_WRITE};
        byte_d    = B_DEV_W;
        bit_d     = '0;
        ack_err_d = 1'b0;
        state_d   = ST_START;
      end
      ST_START: if (slot_end) state_d = ST_TXBYTE;
      ST_TXBYTE: if (slot_end) begin
        sh_d  = {sh_q[6:0], 1'b0};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = ST_RXACK;
      end
      ST_RXACK: begin
        if (rise_end) ack_d = sda_i;
        if (slot_end) begin
          if (ack_q == NACK) begin
            ack_err_d = 1'b1;
            state_d   = ST_STOP;
          end else begin
            unique case (byte_q)
              B_DEV_W: begin
                sh_d = reg_q; byte_d = B_REG; state_d = ST_TXBYTE;
              end
              B_REG: begin
                if (rw_q == RW_READ) state_d = ST_RSTART;
                else begin
                  sh_d = wdata_q; byte_d = B_WDATA; state_d = ST_TXBYTE;
                end
              end
              B_WDATA: state_d = ST_STOP;
              B_DEV_R: state_d = ST_RXBYTE;
            endcase
          end
        end
      end
      ST_RSTART: if (slot_end) begin
        sh_d    = {dev_q, RW_READ};
        byte_d  = B_DEV_R;
        state_d = ST_TXBYTE;
      end
      ST_RXBYTE: begin
        if (rise_end) sh_d = {sh_q[6:0], sda_i};
        if (slot_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            rdata_d = sh_q;
            state_d = ST_TXNACK;
          end
        end
      end
      ST_TXNACK: if (slot_end) state_d = ST_STOP;
      ST_STOP: if (slot_end) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Open-drain drive per slot; START/RSTART pull SDA and STOP releases it
  // while SCL is high, all other SDA changes land on slot edges with SCL low.
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    unique case (state_q)
      ST_IDLE:   ;
      ST_START:  begin scl_oe = (phase == PH_FALL); sda_oe = phase[1]; end
      ST_TXBYTE: begin scl_oe = (phase == PH_SETUP) || (phase == PH_FALL); sda_oe = !sh_q[7]; end
      ST_RSTART: begin scl_oe = (phase == PH_SETUP) || (phase == PH_FALL); sda_oe = phase[1]; end
      ST_STOP:   begin scl_oe = (phase == PH_SETUP); sda_oe = !phase[1]; end
      default:   scl_oe = (phase == PH_SETUP) || (phase == PH_FALL);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      byte_q    <= B_DEV_W;
      bit_q     <= '0;
      sh_q      <= '0;
      rw_q      <= RW_WRITE;
      dev_q     <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      ack_q     <= ACK;
      rdata_q   <= '0;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      rw_q      <= rw_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      ack_err_q <= ack_err_d;
      done_q    <= done_d;
      rdy_q     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Randomised scoreboard bench for i2c_master (DIV=4) with a behavioural
// register slave at 0x70; stretch test active when I2C_MASTER_STRETCH_EN is set.
module tb_i2c_master;

  localparam int         DIV        = 4;
  localparam logic [6:0] SLAVE_ADDR = 7'h70;
  localparam int         TOK_S      = 256;
  localparam int         TOK_P      = 257;
  localparam int         TOK_ACK    = 300;

  typedef struct {
    logic       ack_err;
    logic [7:0] rdata;
  } result_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic scl_oe, sda_oe;
  logic scl_line, sda_line;
  logic slave_sda_low = 1'b0;
  logic stretch_hold  = 1'b0;

  always #5 clk = ~clk;

  i2c_master_if host ();

  assign scl_line = !(scl_oe || stretch_hold);
  assign sda_line = !(sda_oe || slave_sda_low);

  i2c_master #(.DIV(DIV)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .host   (host),
    .scl_oe (scl_oe),
    .scl_i  (scl_line),
    .sda_oe (sda_oe),
    .sda_i  (sda_line)
  );

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  int      exp_tok[$];
  int      bus_q[$];
  result_t exp_res[$];
  logic [7:0] model_mem [256];
  logic [7:0] slave_mem [256];
  logic [7:0] cur_rdata = 8'h00;
  bit slave_en = 1'b0;
  bit stretch_armed = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the bus token sequence and completion result a command
  // must produce, derived from the transaction rules alone.
  task automatic model_cmd(bit rw, logic [6:0] dev, logic [7:0] rg, logic [7:0] wd);
    bit present = (dev == SLAVE_ADDR);
    result_t r;
    exp_tok.push_back(TOK_S);
    exp_tok.push_back(int'({dev, 1'b0}));
    exp_tok.push_back(TOK_ACK + (present ? 0 : 1));
    if (!present) begin
      exp_tok.push_back(TOK_P);
      r.ack_err = 1'b1;
      r.rdata   = cur_rdata;
    end else begin
      exp_tok.push_back(int'(rg));
      exp_tok.push_back(TOK_ACK);
      if (!rw) begin
        exp_tok.push_back(int'(wd));
        exp_tok.push_back(TOK_ACK);
        model_mem[rg] = wd;
      end else begin
        exp_tok.push_back(TOK_S);
        exp_tok.push_back(int'({dev, 1'b1}));
        exp_tok.push_back(TOK_ACK);
        exp_tok.push_back(int'(model_mem[rg]));
        exp_tok.push_back(TOK_ACK + 1);
        cur_rdata = model_mem[rg];
      end
      exp_tok.push_back(TOK_P);
      r.ack_err = 1'b0;
      r.rdata   = cur_rdata;
    end
    exp_res.push_back(r);
  endtask

  task automatic send(bit rw, logic [6:0] dev, logic [7:0] rg, logic [7:0] wd);
    int n = 0;
    @(negedge clk);
    while (!host.cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_cmd", 32'(host.cmd_ready), 32'd1);
    check("rdata_stable", 32'(host.rdata), 32'(cur_rdata));
    host.cmd_rw    = rw;
    host.cmd_dev   = dev;
    host.cmd_reg   = rg;
    host.cmd_wdata = wd;
    host.cmd_valid = 1'b1;
    model_cmd(rw, dev, rg, wd);
    @(negedge clk);
    host.cmd_valid = 1'b0;
    host.cmd_rw    = 1'($urandom);
    host.cmd_dev   = 7'($urandom);
    host.cmd_reg   = 8'($urandom);
    host.cmd_wdata = 8'($urandom);
    check("busy_after_accept", 32'(host.cmd_ready), 32'd0);
  endtask

  task automatic wait_done();
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(done_cnt != start), 32'd1);
  endtask

  // Token monitor: every bus event the slave observes is matched in order.
  initial begin : token_monitor
    int tok;
    forever begin
      @(negedge clk);
      while (bus_q.size() > 0) begin
        tok = bus_q.pop_front();
        if (exp_tok.size() == 0) check("unexpected_bus_token", 32'(tok), 32'hFFFF);
        else check("bus_token", 32'(tok), 32'(exp_tok.pop_front()));
      end
    end
  end

  // Completion monitor: each done pulse is matched against the next result.
  initial begin : done_monitor
    result_t r;
    forever begin
      @(negedge clk);
      if (host.done === 1'b1) begin
        done_cnt++;
        if (exp_res.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else begin
          r = exp_res.pop_front();
          check("ack_err", 32'(host.ack_err), 32'(r.ack_err));
          check("rdata", 32'(host.rdata), 32'(r.rdata));
          check("idle_at_done", 32'(host.cmd_ready), 32'd1);
          check("tokens_drained", 32'(exp_tok.size()), 32'd0);
        end
      end
    end
  end

  // Behavioural register slave, sampled once per clk on the falling edge.
  initial begin : slave_model
    logic prev_scl, prev_sda, scl, sda;
    logic [7:0] s_sh, s_tx, s_ptr;
    int s_bit, s_byte, st_cnt, hi_cnt;
    bit s_active, s_rx, s_hit, s_read, hi_meas;
    prev_scl = 1'b1; prev_sda = 1'b1; s_sh = '0; s_tx = '0; s_ptr = '0;
    s_bit = 0; s_byte = 0; st_cnt = 0; hi_cnt = 0;
    s_active = 0; s_rx = 1; s_hit = 0; s_read = 0; hi_meas = 0;
    forever begin
      @(negedge clk);
      if (!slave_en) begin
        s_active = 0; s_bit = 0; hi_meas = 0;
        slave_sda_low = 1'b0; stretch_hold = 1'b0;
        prev_scl = 1'b1; prev_sda = 1'b1;
      end else begin
        scl = scl_line;
        sda = sda_line;
        if (prev_scl && scl && prev_sda && !sda) begin
          bus_q.push_back(TOK_S);
          s_active = 1; s_bit = 0; s_byte = 0; s_rx = 1;
        end else if (prev_scl && scl && !prev_sda && sda) begin
          if (s_active) bus_q.push_back(TOK_P);
          s_active = 0;
        end else if (s_active && !prev_scl && scl) begin
          if (s_bit < 8) begin
            s_sh = {s_sh[6:0], sda};
            s_bit++;
            if (s_bit == 8) bus_q.push_back(int'(s_sh));
          end else if (s_bit == 8) begin
            bus_q.push_back(TOK_ACK + int'(sda));
            s_bit = 9;
          end
        end else if (s_active && prev_scl && !scl) begin
          if (s_bit == 8) begin
            if (s_rx) begin
              if (s_byte == 0) begin
                s_hit  = (s_sh[7:1] == SLAVE_ADDR);
                s_read = s_sh[0];
              end else if (s_hit && !s_read && s_byte == 1) s_ptr = s_sh;
              else if (s_hit && !s_read) begin
                slave_mem[s_ptr] = s_sh;
                s_ptr++;
              end
              slave_sda_low = s_hit;
              s_byte++;
            end else slave_sda_low = 1'b0;
          end else if (s_bit == 9) begin
            s_bit = 0;
            slave_sda_low = 1'b0;
            if (s_rx && s_hit && s_read && s_byte == 1) begin
              s_rx = 0;
              s_tx = slave_mem[s_ptr];
              slave_sda_low = !s_tx[7];
            end
          end else if (!s_rx && s_bit > 0) slave_sda_low = !s_tx[7-s_bit];
          if (stretch_armed && s_rx && s_bit == 3) begin
            stretch_armed = 0;
            stretch_hold  = 1'b1;
            st_cnt        = 2 * DIV + 20;
          end
        end
        if (stretch_hold) begin
          st_cnt--;
          if (st_cnt == 0) begin
            stretch_hold = 1'b0;
            hi_meas = 1; hi_cnt = 0;
          end
        end else if (hi_meas) begin
          if (scl_line) hi_cnt++;
          else begin
            check("stretch_high_len", 32'(hi_cnt >= 2*DIV-1 && hi_cnt <= 2*DIV), 32'd1);
            hi_meas = 0;
          end
        end
        prev_scl = scl;
        prev_sda = sda;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int busy_done;
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = 8'(i * 7 + 3);
      slave_mem[i] = 8'(i * 7 + 3);
    end
    model_mem[2] = 8'h3C;
    slave_mem[2] = 8'h3C;
    host.cmd_valid = 1'b0;
    host.cmd_rw    = 1'b0;
    host.cmd_dev   = '0;
    host.cmd_reg   = '0;
    host.cmd_wdata = '0;

    #2 rst_n = 1'b0;
    #2;
    check("rst_scl_oe", 32'(scl_oe), 32'd0);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_done", 32'(host.done), 32'd0);
    check("rst_ack_err", 32'(host.ack_err), 32'd0);
    check("rst_rdata", 32'(host.rdata), 32'd0);
    check("rst_cmd_ready", 32'(host.cmd_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    slave_en = 1'b1;
    @(posedge clk);
    #1 check("ready_after_reset", 32'(host.cmd_ready), 32'd1);

    send(1'b0, 7'h70, 8'h05, 8'hA5); wait_done();
    send(1'b1, 7'h70, 8'h02, 8'h00); wait_done();
    send(1'b0, 7'h23, 8'h11, 8'h22); wait_done();
    send(1'b1, 7'h70, 8'h05, 8'h00); wait_done();

    // A second command while busy must be dropped entirely.
    send(1'b0, 7'h70, 8'h40, 8'h99);
    repeat (60) @(negedge clk);
    host.cmd_valid = 1'b1;
    host.cmd_rw    = 1'b1;
    host.cmd_dev   = 7'h70;
    host.cmd_reg   = 8'h02;
    repeat (3) begin
      @(negedge clk);
      check("ready_while_busy", 32'(host.cmd_ready), 32'd0);
    end
    host.cmd_valid = 1'b0;
    wait_done();
    busy_done = done_cnt;
    repeat (300) @(negedge clk);
    check("no_extra_done", 32'(done_cnt), 32'(busy_done));
    check("no_extra_result", 32'(exp_res.size()), 32'd0);

`ifdef I2C_MASTER_STRETCH_EN
    stretch_armed = 1'b1;
    send(1'b0, 7'h70, 8'h33, 8'h5A); wait_done();
    check("stretch_consumed", 32'(stretch_armed), 32'd0);
`endif

    // Reset in the middle of a byte abandons the transfer without STOP.
    send(1'b0, 7'h23, 8'h01, 8'h02);
    repeat (40) @(posedge clk);
    #2 rst_n = 1'b0;
    slave_en = 1'b0;
    #1;
    check("abort_scl_oe", 32'(scl_oe), 32'd0);
    check("abort_sda_oe", 32'(sda_oe), 32'd0);
    check("abort_cmd_ready", 32'(host.cmd_ready), 32'd0);
    check("abort_rdata", 32'(host.rdata), 32'd0);
    exp_tok.delete();
    exp_res.delete();
    bus_q.delete();
    cur_rdata = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    slave_en = 1'b1;
    @(posedge clk);
    #1 check("ready_after_abort", 32'(host.cmd_ready), 32'd1);
    send(1'b0, 7'h70, 8'h06, 8'h6B); wait_done();
    send(1'b1, 7'h70, 8'h06, 8'h00); wait_done();

    for (int i = 0; i < 16; i++) begin
      logic [6:0] dev;
      dev = ($urandom_range(0, 2) != 0) ? SLAVE_ADDR : 7'($urandom_range(0, 127));
      send(1'($urandom), dev, 8'($urandom), 8'($urandom));
      wait_done();
    end

    repeat (20) @(negedge clk);
    check("final_results_drained", 32'(exp_res.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
